// File: rtl/gpmc_pkg.sv
// Shared definitions for the GPMC initiator: AD bus width, default phase timing,
// FSM state encoding and a helper that clamps phase lengths to at least one cycle.
// Ports: none (package only).
package gpmc_pkg;

    localparam int AD_W         = 16;
    localparam int DEF_ADDR_CYC = 2;
    localparam int DEF_ACC_CYC  = 4;
    localparam int DEF_RCV_CYC  = 2;
    localparam int DEF_CNT_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADV_HOLD = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_RD_TURN  = 3'd4,
        ST_RD_ACC   = 3'd5,
        ST_RECOVER  = 3'd6
    } gpmc_state_t;

    // A programmed length of 0 behaves like 1 so every phase is visible on the bus.
    function automatic int cyc_min1(input int cyc);
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/gpmc_phase_timer.sv
// Loadable down-counter that times one bus phase; o_zero marks the last cycle of the phase.
// Latency: load takes effect on the next rising edge; o_zero is a decode of the count register.
// Backpressure: none. Ports: i_clk/i_rst_n, i_load + i_load_val (N-1), o_zero.
module gpmc_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Holds at zero rather than wrapping, so a phase can never stretch by 2**CNT_W cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gpmc_master.sv
// GPMC async multiplexed 16-bit bus initiator: one valid/ready request -> one bus cycle.
// Latency: accept edge to RSP_VALID = ADDR+1+ACC+RCV+1 (write), ADDR+2+ACC+RCV+1 (read).
// Backpressure: o_req_ready is high only in IDLE, including the cycle o_rsp_valid pulses.
// Ports: i_clk_100m/i_rst_n; i_req_* request in, o_req_ready; o_rsp_valid/o_rsp_rdata response;
//        o_gpmc_* registered bus strobes and AD output/enable, i_gpmc_ad_i AD input; o_busy.
module gpmc_master
    import gpmc_pkg::*;
#(
    parameter int ADDR_CYC = DEF_ADDR_CYC,
    parameter int ACC_CYC  = DEF_ACC_CYC,
    parameter int RCV_CYC  = DEF_RCV_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic            i_clk_100m,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [AD_W-1:0] i_req_addr,
    input  logic [AD_W-1:0] i_req_wdata,
    input  logic            i_req_be0n,
    output logic            o_rsp_valid,
    output logic [AD_W-1:0] o_rsp_rdata,
    output logic [AD_W-1:0] o_gpmc_ad_o,
    output logic            o_gpmc_ad_oe,
    input  logic [AD_W-1:0] i_gpmc_ad_i,
    output logic            o_gpmc_advn,
    output logic            o_gpmc_csn1,
    output logic            o_gpmc_wein,
    output logic            o_gpmc_oen,
    output logic            o_gpmc_be0n,
    output logic            o_busy
);

    localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(cyc_min1(ADDR_CYC) - 1);
    localparam logic [CNT_W-1:0] LD_ACC  = CNT_W'(cyc_min1(ACC_CYC) - 1);
    localparam logic [CNT_W-1:0] LD_RCV  = CNT_W'(cyc_min1(RCV_CYC) - 1);

    gpmc_state_t     r_state;
    gpmc_state_t     w_next;
    logic            w_zero;
    logic            w_load;
    logic [CNT_W-1:0] w_load_val;

    logic            r_we;
    logic [AD_W-1:0] r_wdata;
    logic [AD_W-1:0] r_rd_cap;

    gpmc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk_100m),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Next-state decode. Every phase exits to a different state, so any state
    // change is a phase entry and reloads the timer with that phase's length-1.
    always_comb begin
        w_next     = r_state;
        w_load_val = '0;
        case (r_state)
            ST_IDLE:     if (i_req_valid) w_next = ST_ADDR;
            ST_ADDR:     if (w_zero)      w_next = ST_ADV_HOLD;
            ST_ADV_HOLD: if (w_zero)      w_next = r_we ? ST_WR_DATA : ST_RD_TURN;
            ST_WR_DATA:  if (w_zero)      w_next = ST_RECOVER;
            ST_RD_TURN:  if (w_zero)      w_next = ST_RD_ACC;
            ST_RD_ACC:   if (w_zero)      w_next = ST_RECOVER;
            ST_RECOVER:  if (w_zero)      w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
        w_load = (w_next != r_state);
        case (w_next)
            ST_ADDR:    w_load_val = LD_ADDR;
            ST_WR_DATA: w_load_val = LD_ACC;
            ST_RD_ACC:  w_load_val = LD_ACC;
            ST_RECOVER: w_load_val = LD_RCV;
            default:    w_load_val = '0;
        endcase
    end

    // State and all bus outputs are registered from the next state, so the pins
    // change exactly on the phase-entry edge and never glitch.
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_rd_cap     <= '0;
            o_req_ready  <= 1'b1;
            o_busy       <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_rdata  <= '0;
            o_gpmc_ad_o  <= '0;
            o_gpmc_ad_oe <= 1'b0;
            o_gpmc_advn  <= 1'b1;
            o_gpmc_csn1  <= 1'b1;
            o_gpmc_wein  <= 1'b1;
            o_gpmc_oen   <= 1'b1;
            o_gpmc_be0n  <= 1'b1;
        end else begin
            r_state     <= w_next;
            o_req_ready <= (w_next == ST_IDLE);
            o_busy      <= (w_next != ST_IDLE);
            o_rsp_valid <= (r_state == ST_RECOVER) && (w_next == ST_IDLE);

            // Sample the slave's data on the final access cycle, while OEN is still low.
            if (r_state == ST_RD_ACC && w_zero) begin
                r_rd_cap <= i_gpmc_ad_i;
            end
            // Published only with the response so the old value stays stable until then.
            if (r_state == ST_RECOVER && w_next == ST_IDLE) begin
                o_rsp_rdata <= r_we ? '0 : r_rd_cap;
            end

            if (w_next != r_state) begin
                case (w_next)
                    ST_ADDR: begin
                        // Entered only from IDLE on the accept edge: take REQ_* directly.
                        r_we         <= i_req_we;
                        r_wdata      <= i_req_wdata;
                        o_gpmc_ad_o  <= i_req_addr;
                        o_gpmc_ad_oe <= 1'b1;
                        o_gpmc_csn1  <= 1'b0;
                        o_gpmc_advn  <= 1'b0;
                        o_gpmc_be0n  <= i_req_be0n;
                        o_gpmc_wein  <= 1'b1;
                        o_gpmc_oen   <= 1'b1;
                    end
                    ST_ADV_HOLD: begin
                        o_gpmc_advn <= 1'b1;
                    end
                    ST_WR_DATA: begin
                        o_gpmc_ad_o <= r_wdata;
                        o_gpmc_wein <= 1'b0;
                    end
                    ST_RD_TURN: begin
                        // Release AD a full cycle before OEN lets the slave drive it.
                        o_gpmc_ad_oe <= 1'b0;
                        o_gpmc_oen   <= 1'b1;
                    end
                    ST_RD_ACC: begin
                        o_gpmc_oen <= 1'b0;
                    end
                    ST_RECOVER: begin
                        o_gpmc_ad_oe <= 1'b0;
                        o_gpmc_csn1  <= 1'b1;
                        o_gpmc_advn  <= 1'b1;
                        o_gpmc_wein  <= 1'b1;
                        o_gpmc_oen   <= 1'b1;
                        o_gpmc_be0n  <= 1'b1;
                    end
                    default: begin
                        o_gpmc_ad_oe <= 1'b0;
                        o_gpmc_csn1  <= 1'b1;
                        o_gpmc_advn  <= 1'b1;
                        o_gpmc_wein  <= 1'b1;
                        o_gpmc_oen   <= 1'b1;
                        o_gpmc_be0n  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpmc_master.sv
// Directed bench for gpmc_master: vector table of single accesses on a default-timing
// instance, plus hand sequences for back-to-back, mid-access reset and minimum timing.
module tb_gpmc_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // default-timing instance
    logic        req_valid, req_ready, req_we, req_be0n;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, ad_oe, advn, csn1, wein, oen, be0n, busy;
    logic [15:0] rsp_rdata, ad_o, ad_i;

    // minimum-timing instance
    logic        req_valid2, req_ready2, req_we2, req_be0n2;
    logic [15:0] req_addr2, req_wdata2;
    logic        rsp_valid2, ad_oe2, advn2, csn12, wein2, oen2, be0n2, busy2;
    logic [15:0] rsp_rdata2, ad_o2, ad_i2;

    logic [15:0] rd_val;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    gpmc_master #(.ADDR_CYC(2), .ACC_CYC(4), .RCV_CYC(2), .CNT_W(4)) u_dut (
        .i_clk_100m(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be0n(req_be0n),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_gpmc_ad_o(ad_o), .o_gpmc_ad_oe(ad_oe), .i_gpmc_ad_i(ad_i),
        .o_gpmc_advn(advn), .o_gpmc_csn1(csn1), .o_gpmc_wein(wein),
        .o_gpmc_oen(oen), .o_gpmc_be0n(be0n), .o_busy(busy)
    );

    gpmc_master #(.ADDR_CYC(1), .ACC_CYC(1), .RCV_CYC(1), .CNT_W(4)) u_dut_min (
        .i_clk_100m(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid2), .o_req_ready(req_ready2), .i_req_we(req_we2),
        .i_req_addr(req_addr2), .i_req_wdata(req_wdata2), .i_req_be0n(req_be0n2),
        .o_rsp_valid(rsp_valid2), .o_rsp_rdata(rsp_rdata2),
        .o_gpmc_ad_o(ad_o2), .o_gpmc_ad_oe(ad_oe2), .i_gpmc_ad_i(ad_i2),
        .o_gpmc_advn(advn2), .o_gpmc_csn1(csn12), .o_gpmc_wein(wein2),
        .o_gpmc_oen(oen2), .o_gpmc_be0n(be0n2), .o_busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: drives read data only while OEN is low, otherwise zero.
    always @(negedge clk) begin
        ad_i  = oen  ? 16'h0000 : rd_val;
        ad_i2 = oen2 ? 16'h0000 : rd_val;
    end

    // Bus safety: AD never driven while OEN is low; OEN and WEIN never low together.
    always @(negedge clk) begin
        if (rst_n) begin
            check("oe_while_oen",    {31'd0, ad_oe  & ~oen},   32'd0);
            check("oen_and_wein",    {31'd0, ~oen   & ~wein},  32'd0);
            check("oe_while_oen_m",  {31'd0, ad_oe2 & ~oen2},  32'd0);
            check("oen_and_wein_m",  {31'd0, ~oen2  & ~wein2}, 32'd0);
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd_drive;
        logic [15:0] exp_rdata;
        logic        be0n;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    // One access on the default instance; phase lengths counted at negedges.
    task automatic run_txn(input vec_t v);
        int  acc_cyc, lat, budget;
        int  n_addr, n_hold, n_wr, n_oen, n_turn, n_be_bad;
        bit  accepted, done;
        rd_val = v.rd_drive;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_be0n = v.be0n;
        accepted = 0; budget = 0;
        while (!accepted && budget < 50) begin
            if (req_ready) accepted = 1;
            else begin @(negedge clk); budget++; end
        end
        check("accept", {31'd0, accepted}, 32'd1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        // Request inputs change after capture; the bus must not follow them.
        req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_be0n = ~v.be0n;
        done = 0; budget = 0; lat = 0;
        n_addr = 0; n_hold = 0; n_wr = 0; n_oen = 0; n_turn = 0; n_be_bad = 0;
        while (!done && budget < 40) begin
            if (!csn1 && !advn && ad_oe && ad_o == v.addr) n_addr++;
            if (!csn1 && advn && ad_oe && wein && ad_o == v.addr) n_hold++;
            if (!wein && ad_oe && ad_o == v.wdata) n_wr++;
            if (!oen && !ad_oe) n_oen++;
            if (!csn1 && advn && oen && wein && !ad_oe) n_turn++;
            if (!csn1 && be0n != v.be0n) n_be_bad++;
            if (rsp_valid) begin
                done = 1;
                lat = cyc + 1 - acc_cyc;
            end else begin
                @(negedge clk); budget++;
            end
        end
        check("rsp_seen",   {31'd0, done}, 32'd1);
        check("latency",    32'(lat), 32'(v.exp_lat));
        check("rsp_rdata",  {16'd0, rsp_rdata}, {16'd0, v.exp_rdata});
        check("ready_at_rsp", {31'd0, req_ready}, 32'd1);
        check("addr_cycles", 32'(n_addr), 32'd2);
        check("hold_cycles", 32'(n_hold), 32'd1);
        check("wr_cycles",   32'(n_wr),   v.we ? 32'd4 : 32'd0);
        check("oen_cycles",  32'(n_oen),  v.we ? 32'd0 : 32'd4);
        check("turn_cycles", 32'(n_turn), v.we ? 32'd0 : 32'd1);
        check("be0n_level",  32'(n_be_bad), 32'd0);
        @(negedge clk);
        check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check("rdata_held",  {16'd0, rsp_rdata}, {16'd0, v.exp_rdata});
        check("idle_busy",   {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int budget, acc1, acc2, lat, n_gap, n_rsp, n_oen_m;
        bit done;

        vecs[0] = '{1'b1, 16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 10};
        vecs[1] = '{1'b0, 16'h0042, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0, 11};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5C3, 16'hA5C3, 1'b1, 11};
        vecs[3] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 10};

        rst_n = 1'b0; rd_val = 16'h0000;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be0n = 1'b1;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; req_be0n2 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_strobes", {27'd0, csn1, advn, wein, oen, be0n}, 32'h1F);
        check("rst_ad_oe",   {31'd0, ad_oe}, 32'd0);
        check("rst_ad_o",    {16'd0, ad_o}, 32'd0);
        check("rst_ready",   {31'd0, req_ready}, 32'd1);
        check("rst_rsp",     {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);

        for (int i = 0; i < 4; i++) run_txn(vecs[i]);

        // Back-to-back: valid held high across a write then a read.
        rd_val = 16'h3C3C;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100; req_wdata = 16'h0F0F; req_be0n = 1'b0;
        check("b2b_ready1", {31'd0, req_ready}, 32'd1);
        acc1 = cyc + 1;
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'h0200; req_wdata = 16'h0000;
        done = 0; budget = 0; n_gap = 0; acc2 = 0;
        while (!done && budget < 40) begin
            if (csn1) n_gap++;
            if (rsp_valid) begin
                done = 1;
                check("b2b_lat1", 32'(cyc + 1 - acc1), 32'd10);
                check("b2b_ready_at_rsp", {31'd0, req_ready}, 32'd1);
                check("b2b_rdata1", {16'd0, rsp_rdata}, 32'd0);
                acc2 = cyc + 1;
            end else begin
                @(negedge clk); budget++;
            end
        end
        check("b2b_rsp1_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        // Gap = recovery cycles plus the IDLE cycle in which the next request is taken.
        check("b2b_csn_gap", 32'(n_gap), 32'd3);
        check("b2b_second_started", {31'd0, csn1}, 32'd0);
        done = 0; budget = 0;
        while (!done && budget < 40) begin
            if (rsp_valid) begin
                done = 1;
                check("b2b_lat2", 32'(cyc + 1 - acc2), 32'd11);
                check("b2b_rdata2", {16'd0, rsp_rdata}, 32'h3C3C);
            end else begin
                @(negedge clk); budget++;
            end
        end
        check("b2b_rsp2_seen", {31'd0, done}, 32'd1);

        // Reset asserted in the middle of the read access phase.
        repeat (2) @(negedge clk);
        rd_val = 16'h1357;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0777; req_be0n = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        budget = 0;
        while (oen && budget < 30) begin @(negedge clk); budget++; end
        check("rst_mid_in_rd_acc", {31'd0, oen}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {28'd0, csn1, oen, advn, wein}, 32'hF);
        check("rst_mid_ad_oe",   {31'd0, ad_oe}, 32'd0);
        n_rsp = 0;
        repeat (2) @(negedge clk) if (rsp_valid) n_rsp++;
        rst_n = 1'b1;
        repeat (15) @(negedge clk) if (rsp_valid) n_rsp++;
        check("rst_mid_no_rsp", 32'(n_rsp), 32'd0);
        check("rst_mid_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_mid_busy",   {31'd0, busy}, 32'd0);

        // Minimum timing read on the second instance.
        rd_val = 16'hC0DE;
        @(negedge clk);
        req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 16'h0013; req_be0n2 = 1'b0;
        check("min_ready", {31'd0, req_ready2}, 32'd1);
        acc1 = cyc + 1;
        @(negedge clk);
        req_valid2 = 1'b0;
        done = 0; budget = 0; n_oen_m = 0; lat = 0;
        while (!done && budget < 30) begin
            if (!oen2) n_oen_m++;
            if (rsp_valid2) begin
                done = 1;
                lat = cyc + 1 - acc1;
            end else begin
                @(negedge clk); budget++;
            end
        end
        check("min_rsp_seen", {31'd0, done}, 32'd1);
        check("min_latency", 32'(lat), 32'd6);
        check("min_rdata",   {16'd0, rsp_rdata2}, 32'hC0DE);
        check("min_oen_cycles", 32'(n_oen_m), 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
